multi_ch_reg_fifo: RTL and testbench

- Register-based synchronous FIFO generalised to NUM_CH independent channels with a shared write port and a shared read port.
- Writes are steered by a channel tag. The read side picks one non-empty channel per cycle with a round-robin arbiter and loads a registered output stage that carries data plus channel tag.
- Used to merge several low-rate streams onto one interleaved datapath.

---
 rtl/multi_ch_reg_fifo_pkg.sv | 17 +
 rtl/multi_ch_reg_fifo_arb.sv | 70 +++++++
 rtl/multi_ch_reg_fifo.sv | 107 ++++++++++
 tb/tb_multi_ch_reg_fifo.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_ch_reg_fifo_pkg.sv
// Shared helpers for multi_ch_reg_fifo: channel tag width and packed count-slice geometry.
package multi_ch_reg_fifo_pkg;

    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // LSB of channel ch inside the packed count vector.
    function automatic int cnt_lsb(input int ch, input int depth);
        return ch * cnt_width(depth);
    endfunction

endpackage

// File: rtl/multi_ch_reg_fifo_arb.sv
// Read-side channel arbiter: round-robin by default, fixed lowest-index priority
// when MULTI_CH_REG_FIFO_STRICT_PRIO_EN is defined (the rotating pointer is then absent).
module rr_arbiter
    import multi_ch_reg_fifo_pkg::*;
#(
    parameter  int NUM_CH   = 4,
    localparam int CH_WIDTH = tag_width(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic [NUM_CH-1:0]   req_i,
    input  logic                advance_i,
    output logic [NUM_CH-1:0]   gnt_o,
    output logic [CH_WIDTH-1:0] gnt_idx_o,
    output logic                gnt_valid_o
);

`ifdef MULTI_CH_REG_FIFO_STRICT_PRIO_EN
    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                gnt_o       = '0;
                gnt_o[k]    = 1'b1;
                gnt_idx_o   = CH_WIDTH'(k);
                gnt_valid_o = 1'b1;
            end
        end
    end

    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, clear_i, advance_i};
`else
    logic [CH_WIDTH-1:0] rr_ptr_q;
    logic [CH_WIDTH-1:0] rr_ptr_d;

    always_comb begin
        int idx;
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        idx         = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_o[idx]  = 1'b1;
                gnt_idx_o   = CH_WIDTH'(idx);
                gnt_valid_o = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance_i && gnt_valid_o)
            rr_ptr_d = (int'(gnt_idx_o) == NUM_CH - 1) ? '0 : gnt_idx_o + CH_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          rr_ptr_q <= '0;
        else if (clear_i) rr_ptr_q <= '0;
        else              rr_ptr_q <= rr_ptr_d;
    end
`endif

endmodule

// File: rtl/multi_ch_reg_fifo.sv
// NUM_CH register FIFOs sharing one write port and one arbitrated, registered read port.
// Arbitration policy selected by MULTI_CH_REG_FIFO_STRICT_PRIO_EN (see rr_arbiter).
module multi_ch_reg_fifo
    import multi_ch_reg_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH    = 8,
    parameter  int FIFO_DEPTH    = 4,
    parameter  int NUM_CH        = 4,
    localparam int LB_FIFO_DEPTH = $clog2(FIFO_DEPTH),
    localparam int CH_WIDTH      = tag_width(NUM_CH),
    localparam int CW            = cnt_width(FIFO_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [CH_WIDTH-1:0]    in_ch,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [CH_WIDTH-1:0]    out_ch,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   clear,
    output logic [NUM_CH*CW-1:0]   count,
    output logic [NUM_CH-1:0]      empty,
    output logic [NUM_CH-1:0]      full
);

    logic [DATA_WIDTH-1:0]    mem_q    [NUM_CH][FIFO_DEPTH];
    logic [LB_FIFO_DEPTH-1:0] wr_ptr_q [NUM_CH];
    logic [LB_FIFO_DEPTH-1:0] rd_ptr_q [NUM_CH];
    logic [CW-1:0]            cnt_q    [NUM_CH];
    logic [DATA_WIDTH-1:0]    out_data_q;
    logic [CH_WIDTH-1:0]      out_ch_q;
    logic                     out_valid_q;

    logic [NUM_CH-1:0]   wr_hit;
    logic [NUM_CH-1:0]   gnt;
    logic [CH_WIDTH-1:0] gnt_idx;
    logic                gnt_valid;
    logic                load;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_stat
        assign count[cnt_lsb(c, FIFO_DEPTH) +: CW] = cnt_q[c];
        assign empty[c] = (cnt_q[c] == '0);
        assign full[c]  = (cnt_q[c] == CW'(FIFO_DEPTH));
    end

    // in_ready depends only on registered occupancy, never on out_ready.
    always_comb begin
        in_ready = (int'(in_ch) < NUM_CH) && !full[in_ch];
        wr_hit   = '0;
        if (in_valid && in_ready) wr_hit[in_ch] = 1'b1;
        load = (!out_valid_q || out_ready) && gnt_valid;
    end

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear),
        .req_i       (~empty),
        .advance_i   (load),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int i = 0; i < FIFO_DEPTH; i++) mem_q[c][i] <= '0;
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_hit[c]) begin
                    mem_q[c][wr_ptr_q[c]] <= in_data;
                    wr_ptr_q[c]           <= wr_ptr_q[c] + LB_FIFO_DEPTH'(1);
                end
                if (load && gnt[c]) rd_ptr_q[c] <= rd_ptr_q[c] + LB_FIFO_DEPTH'(1);
                case ({wr_hit[c], load && gnt[c]})
                    2'b10:   cnt_q[c] <= cnt_q[c] + CW'(1);
                    2'b01:   cnt_q[c] <= cnt_q[c] - CW'(1);
                    default: cnt_q[c] <= cnt_q[c];
                endcase
            end
            // Data/tag hold their last value when the register drains empty.
            if (load) begin
                out_data_q  <= mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
                out_ch_q    <= gnt_idx;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multi_ch_reg_fifo.sv
// Self-checking bench for multi_ch_reg_fifo: queue-based reference model, per-cycle compare, directed literals.
module tb_multi_ch_reg_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int NCH   = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic [1:0]    in_ch = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_ch;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          clear = 1'b0;
    logic [NCH*CW-1:0] count;
    logic [NCH-1:0] empty;
    logic [NCH-1:0] full;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    multi_ch_reg_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .NUM_CH(NCH)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_ch(in_ch), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready), .clear(clear), .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: one queue per channel plus the output register.
    logic [DW-1:0] mq [NCH][$];
    logic          m_ov = 1'b0;
    logic [DW-1:0] m_od = '0;
    logic [1:0]    m_oc = '0;
    int            m_rr = 0;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) mq[c].delete();
        m_ov = 1'b0;
        m_od = '0;
        m_oc = '0;
        m_rr = 0;
    endtask

    always @(posedge clk or posedge rst) begin
        bit acc;
        int g;
        int c;
        if (rst || clear) begin
            model_reset();
        end else begin
            acc = in_valid && (mq[in_ch].size() < DEPTH);
            g = -1;
            if (!m_ov || out_ready) begin
                for (int k = 0; k < NCH; k++) begin
`ifdef MULTI_CH_REG_FIFO_STRICT_PRIO_EN
                    c = k;
`else
                    c = (m_rr + k) % NCH;
`endif
                    if (g < 0 && mq[c].size() > 0) g = c;
                end
            end
            if (g >= 0) begin
                m_od = mq[g].pop_front();
                m_oc = g[1:0];
                m_ov = 1'b1;
                m_rr = (g + 1) % NCH;
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            if (acc) mq[in_ch].push_back(in_data);
        end
    end

    logic          hold_prev = 1'b0;
    logic [DW-1:0] prev_d;
    logic [1:0]    prev_c;

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", out_valid, m_ov);
            check("out_data", out_data, m_od);
            check("out_ch", out_ch, m_oc);
            check("in_ready", in_ready, mq[in_ch].size() < DEPTH);
            for (int c = 0; c < NCH; c++) begin
                check($sformatf("count[%0d]", c), count[c*CW +: CW], mq[c].size());
                check($sformatf("empty[%0d]", c), empty[c], mq[c].size() == 0);
                check($sformatf("full[%0d]", c), full[c], mq[c].size() == DEPTH);
            end
            if (hold_prev && out_valid) begin
                check("hold_data", out_data, prev_d);
                check("hold_ch", out_ch, prev_c);
            end
            hold_prev = out_valid && !out_ready;
            prev_d    = out_data;
            prev_c    = out_ch;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rand_cycle(input int rdy_pct);
        in_valid  = 1'($urandom_range(0, 1));
        in_ch     = 2'($urandom_range(0, NCH - 1));
        in_data   = 8'($urandom_range(0, 8'hED));
        out_ready = ($urandom_range(0, 99) < rdy_pct);
        tick();
    endtask

    logic [DW-1:0] exp_order [5];
    logic [1:0]    exp_ch    [5];

    initial begin
        repeat (2) @(posedge clk);
        #2;
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset mid-run after three writes to ch1
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ch     = 2'd1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(8'h30 + i);
            tick();
        end
        in_valid = 1'b0;
        check("t1_cnt1_before_rst", count[3 +: CW], 2);
        check("t1_ov_before_rst", out_valid, 1);
        check("t1_od_before_rst", out_data, 8'h30);
        rst = 1'b1;
        #1;
        check("t1_rst_ov", out_valid, 0);
        check("t1_rst_count", count, 0);
        check("t1_rst_empty", empty, 4'b1111);
        check("t1_rst_full", full, 4'b0000);
        check("t1_rst_od", out_data, 0);
        tick();
        rst = 1'b0;
        tick();
        #1;
        check("t1_in_ready_after", in_ready, 1);

        // Single channel fill with output stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ch     = 2'd2;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'(8'h11 + i);
            tick();
            if (i == 1) begin
                check("t2_first_load_ov", out_valid, 1);
                check("t2_first_load_od", out_data, 8'h11);
            end
        end
        check("t2_cnt2_full", count[6 +: CW], 4);
        check("t2_full_vec", full, 4'b0100);
        in_data = 8'h16;
        #1;
        check("t2_refused", in_ready, 0);
        in_ch = 2'd0;
        #1;
        check("t2_ch0_ready", in_ready, 1);
        in_ch = 2'd3;
        #1;
        check("t2_ch3_ready", in_ready, 1);
        in_ch = 2'd2;
        tick();
        in_valid  = 1'b0;
        check("t2_cnt2_hold", count[6 +: CW], 4);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t2_drain_ov", out_valid, 1);
            check("t2_drain_od", out_data, 8'(8'h11 + i));
            check("t2_drain_ch", out_ch, 2);
            tick();
        end
        check("t2_drained", out_valid, 0);

        // Arbitration order
        clear = 1'b1;
        tick();
        clear     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ch = 2'd0; in_data = 8'hA0; tick();
        in_ch = 2'd0; in_data = 8'hA1; tick();
        in_ch = 2'd1; in_data = 8'hB0; tick();
        in_ch = 2'd3; in_data = 8'hD0; tick();
        in_ch = 2'd3; in_data = 8'hD1; tick();
        in_valid = 1'b0;
`ifdef MULTI_CH_REG_FIFO_STRICT_PRIO_EN
        exp_order = '{8'hA0, 8'hA1, 8'hB0, 8'hD0, 8'hD1};
        exp_ch    = '{2'd0, 2'd0, 2'd1, 2'd3, 2'd3};
`else
        exp_order = '{8'hA0, 8'hB0, 8'hD0, 8'hA1, 8'hD1};
        exp_ch    = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd3};
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t3_ov", out_valid, 1);
            check("t3_order_data", out_data, exp_order[i]);
            check("t3_order_ch", out_ch, exp_ch[i]);
            tick();
        end
        check("t3_done", out_valid, 0);

        // Full channel: pop and refused write in the same cycle
        clear = 1'b1;
        tick();
        clear     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ch     = 2'd0;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'(8'h40 + i);
            tick();
        end
        check("t4_full0", full[0], 1);
        out_ready = 1'b1;
        in_data   = 8'h45;
        #1;
        check("t4_not_ready", in_ready, 0);
        tick();
        check("t4_cnt0_after_pop", count[0 +: CW], 3);
        out_ready = 1'b0;
        in_data   = 8'h46;
        #1;
        check("t4_ready_again", in_ready, 1);
        tick();
        check("t4_cnt0_refill", count[0 +: CW], 4);
        in_valid = 1'b0;

        // Clear under random traffic
        for (int i = 0; i < 300; i++) rand_cycle(70);
        clear     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hEE;
        out_ready = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("t5_clear_ov", out_valid, 0);
        check("t5_clear_count", count, 0);
        check("t5_clear_empty", empty, 4'b1111);
        for (int i = 0; i < 20; i++) begin
            rand_cycle(100);
            check("t5_no_clear_word", out_valid && (out_data == 8'hEE), 0);
        end

        // Random back-pressure
        for (int i = 0; i < 1200; i++) rand_cycle(50);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (30) tick();
        check("t6_drain_ov", out_valid, 0);
        check("t6_drain_empty", empty, 4'b1111);

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
